axi_rd_responder: RTL and testbench
===================================

Name: axi_rd_responder

Overview:
- AXI4-style read-channel responder (slave) backed by an internal word RAM.
- Serves AR/R traffic from a read initiator, e.g. the instruction-cache refill path: accepts one read address, then returns 1..256 data beats with RLAST.
- Memory contents are preloaded through a synchronous backdoor write port.
- Used as the memory side in cache/fetch simulation and as a simple on-chip boot ROM/RAM.

Parameters:
- MEM_AW, 12, log2 of RAM depth in 32-bit words; word index = addr[MEM_AW+1:2], upper address bits ignored (aliasing).
- RD_LATENCY, 2, idle cycles between AR handshake and first R beat (0..15).

Ports:
- clk  in  1  clock, all logic on posedge
- resetn  in  1  synchronous active-low reset
- ARADDR  in  32  read byte address; bits [1:0] ignored
- ARLEN  in  8  beats minus one
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- ARVALID  in  1  address valid
- ARREADY  out  1  address accepted when ARVALID&ARREADY
- RDATA  out  32  read data
- RRESP  out  2  00 OKAY, 10 SLVERR
- RLAST  out  1  final beat of burst
- RVALID  out  1  data valid
- RREADY  in  1  initiator accepts beat
- mem_we  in  1  backdoor write enable
- mem_waddr  in  MEM_AW  backdoor word index
- mem_wdata  in  32  backdoor write data

Behaviour:
- Reset (resetn low at posedge): state=IDLE; RVALID=0, RLAST=0, RDATA=0, RRESP=00; rst_done=0, so ARREADY=0. RAM contents are not cleared. One cycle after resetn goes high, rst_done=1.
- ARREADY = (state==IDLE) & rst_done, combinational from registers only; never depends on ARVALID.
- States:
  - IDLE: on ARVALID&ARREADY, latch word address, ARLEN and ARBURST; clear beat counter.
    - RD_LATENCY==0: go to BURST and load the first beat.
    - Otherwise: set wait count to RD_LATENCY and go to WAIT.
  - WAIT: decrement count each cycle; when count==1, load the first beat and go to BURST. Occupies exactly RD_LATENCY cycles.
  - BURST: RVALID=1. On RVALID&RREADY:
    - if RLAST: go to IDLE, RVALID=0 next cycle;
    - else: beat+1, advance address, load next beat.
- Timing: the AR handshake cycle is cycle 0, so the first beat is valid in cycle RD_LATENCY+1. With RREADY held high, one beat per cycle. Minimum gap between bursts is one IDLE cycle.
- Beat load: RDATA <= mem[word index]; RRESP <= err; RLAST <= (beat_next==len).
- RDATA, RRESP and RLAST are registers and stay stable while RVALID&~RREADY. RVALID never drops without a handshake.
- Address advance (32-bit byte address, word step 4):
  - FIXED: address unchanged.
  - INCR: +4, wraps modulo 2^32.
  - WRAP: boundary size = (len+1)*4; next = (addr & ~(size-1)) | ((addr+4) & (size-1)).
- err=1 when ARBURST==11, or ARBURST==WRAP with ARLEN not in {1,3,7,15}.
  - All beats of that burst return RRESP=10; data is still read with INCR stepping and the full ARLEN+1 beats are still sent.
- Backdoor: mem_we writes mem[mem_waddr] at posedge in any state. A write to the word currently held in RDATA does not change RDATA; it is visible to later beat loads.
- Reset mid-burst: the burst is aborted immediately with RVALID=0, and no RLAST is ever issued for it.
- ARVALID while not IDLE: ignored (ARREADY=0); the request is accepted in the first IDLE cycle.

Optional Feature:
- Macro: AXI_RSP_STALL_EN.
- Defined:
  - Adds an 8-bit Fibonacci LFSR, seed 8'hA5 at reset, polynomial x^8+x^6+x^5+x^4+1, stepping every cycle.
  - When a beat handshakes and the burst is not finished, if lfsr[1:0]==2'b11, RVALID is deasserted for exactly one bubble cycle before the next beat is presented. The address and beat counter are held during the bubble.
  - The first beat is never delayed beyond RD_LATENCY+1.
- Undefined: no LFSR, no bubbles; timing exactly as in Behaviour.

Test Plan:
- Reset and idle: hold resetn low 3 cycles, then high -> ARREADY=0 in the first cycle after release, ARREADY=1 from the second; RVALID=0 throughout.
- INCR burst: preload mem[i]=32'h1000_0000+i; ARADDR=0x40, ARLEN=3, ARBURST=01, RREADY=1, RD_LATENCY=2 -> RVALID in cycles 3..6; RDATA=0x10000010..0x10000013; RLAST only in cycle 6; RRESP=00.
- WRAP burst: ARADDR=0x48, ARLEN=3, ARBURST=10 -> RDATA 0x10000012, 0x10000013, 0x10000010, 0x10000011, with RLAST on the 4th beat.
- Backpressure: INCR ARLEN=1 with RREADY low for 4 cycles after RVALID rises -> RDATA=0x10000010 stable for 5 cycles, beat 2 follows one cycle after the handshake, ARREADY=0 until RLAST is accepted.
- Error response: ARBURST=10 with ARLEN=2 -> 3 beats of INCR data, RRESP=10 on every beat, RLAST on the 3rd; same check with ARBURST=11.
- Reset mid-burst: ARLEN=7, assert resetn low after beat 3 is accepted -> RVALID=0 at the next edge. A new burst from ARADDR=0 after reset returns mem[0] first.

Source files
------------

// File: rtl/axi_rd_responder.sv
// AXI4-style read responder backed by a word RAM with a synchronous backdoor write port.
// Optional random R-channel bubbles when AXI_RSP_STALL_EN is defined.
module axi_rd_responder #(
  parameter int MEM_AW     = 12,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic              mem_we,
  input  logic [MEM_AW-1:0] mem_waddr,
  input  logic [31:0]       mem_wdata
);

  // state    | meaning
  // S_IDLE   | ready for a new read address (once reset has settled)
  // S_WAIT   | counting down RD_LATENCY before the first beat
  // S_BURST  | beat presented on R, waiting for RREADY
  // S_BUBBLE | one-cycle gap between beats (stall feature only)
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_BUBBLE} state_t;

  state_t      state, state_nxt;
  logic        rst_done;
  logic [31:0] addr, addr_nxt, ld_addr;
  logic [7:0]  len, ld_len, beat, ld_beat;
  logic [1:0]  burst;
  logic        err, ld_err, err_in;
  logic [3:0]  cnt;
  logic        ar_hs, load, adv, stall;
  logic [31:0] mem [2**MEM_AW];

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [7:0] l,
                                            input logic [1:0] b);
    logic [31:0] mask;
    mask = (({24'd0, l} + 32'd1) << 2) - 32'd1;
    case (b)
      2'b00:   step_addr = a;
      2'b10:   step_addr = (a & ~mask) | ((a + 32'd4) & mask);
      default: step_addr = a + 32'd4;
    endcase
  endfunction

  assign ARREADY  = (state == S_IDLE) && rst_done;
  assign RVALID   = (state == S_BURST);
  assign ar_hs    = ARVALID && ARREADY;
  assign addr_nxt = step_addr(addr, len, burst);
  assign err_in   = (ARBURST == 2'b11) ||
                    ((ARBURST == 2'b10) && !((ARLEN == 8'd1) || (ARLEN == 8'd3) ||
                                             (ARLEN == 8'd7) || (ARLEN == 8'd15)));

`ifdef AXI_RSP_STALL_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk) begin
    if (!resetn) lfsr <= 8'hA5;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign stall = (lfsr[1:0] == 2'b11);
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    ld_addr   = addr;
    ld_len    = len;
    ld_beat   = beat;
    ld_err    = err;
    case (state)
      S_IDLE: begin
        if (ar_hs) begin
          ld_addr = ARADDR;
          ld_len  = ARLEN;
          ld_beat = 8'd0;
          ld_err  = err_in;
          if (RD_LATENCY == 0) begin
            load      = 1'b1;
            state_nxt = S_BURST;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          load      = 1'b1;
          state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (RREADY) begin
          if (RLAST) begin
            state_nxt = S_IDLE;
          end else if (stall) begin
            state_nxt = S_BUBBLE;
          end else begin
            load    = 1'b1;
            adv     = 1'b1;
            ld_addr = addr_nxt;
            ld_beat = beat + 8'd1;
          end
        end
      end
      S_BUBBLE: begin
        load      = 1'b1;
        adv       = 1'b1;
        ld_addr   = addr_nxt;
        ld_beat   = beat + 8'd1;
        state_nxt = S_BURST;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Backdoor port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rst_done <= 1'b0;
      addr     <= 32'd0;
      len      <= 8'd0;
      burst    <= 2'b00;
      err      <= 1'b0;
      beat     <= 8'd0;
      cnt      <= 4'd0;
      RDATA    <= 32'd0;
      RRESP    <= 2'b00;
      RLAST    <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (ar_hs) begin
        addr  <= ARADDR;
        len   <= ARLEN;
        burst <= err_in ? 2'b01 : ARBURST;
        err   <= err_in;
        beat  <= 8'd0;
        cnt   <= 4'(RD_LATENCY);
      end
      if (state == S_WAIT) cnt <= cnt - 4'd1;
      if (adv) begin
        addr <= addr_nxt;
        beat <= beat + 8'd1;
      end
      if (load) begin
        RDATA <= mem[ld_addr[MEM_AW+1:2]];
        RRESP <= ld_err ? 2'b10 : 2'b00;
        RLAST <= (ld_beat == ld_len);
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Scoreboard bench for axi_rd_responder: directed AR bursts, expected beats queued, monitor checks R.
module tb_axi_rd_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic        mem_we = 1'b0;
  logic [11:0] mem_waddr = '0;
  logic [31:0] mem_wdata = '0;

  axi_rd_responder dut (
    .clk(clk), .resetn(resetn),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    int          at;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic void push(input logic [31:0] d, input logic [1:0] r, input logic l,
                               input int at);
    beat_t b;
    b.data = d; b.resp = r; b.last = l; b.at = at;
    exp_q.push_back(b);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: every R handshake is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (RVALID === 1'b1 && RREADY === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL r_beat: unexpected beat data=%h resp=%b last=%b (cycle %0d)",
                 RDATA, RRESP, RLAST, cyc);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if (RDATA !== e.data || RRESP !== e.resp || RLAST !== e.last ||
            (e.at >= 0 && cyc != e.at)) begin
          n_fail++;
          $display("FAIL r_beat: got data=%h resp=%b last=%b cycle=%0d expected data=%h resp=%b last=%b cycle=%0d",
                   RDATA, RRESP, RLAST, cyc, e.data, e.resp, e.last, e.at);
        end
      end
    end
  end

  task automatic do_ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                       output int c);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    ARADDR = a; ARLEN = l; ARBURST = b; ARVALID = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ARREADY === 1'b1) begin ok = 1'b1; break; end
    end
    c = cyc;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ar_accept: ARREADY never rose, expected 1 within 100 cycles");
    end
    @(posedge clk); #1;
    ARVALID = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    check({name, "_rvalid_idle"}, {31'd0, RVALID}, 32'd0);
  endtask

  int c;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rvalid", {31'd0, RVALID}, 32'd0);
      check("rst_arready", {31'd0, ARREADY}, 32'd0);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rel_arready_c1", {31'd0, ARREADY}, 32'd0);
    check("rel_rdata", RDATA, 32'd0);
    @(negedge clk);
    check("rel_arready_c2", {31'd0, ARREADY}, 32'd1);
    check("rel_rvalid", {31'd0, RVALID}, 32'd0);

    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      mem_we = 1'b1; mem_waddr = 12'(i); mem_wdata = 32'h1000_0000 + i;
    end
    @(posedge clk); #1;
    mem_we = 1'b0;

    // INCR burst
    RREADY = 1'b1;
    do_ar(32'h40, 8'd3, 2'b01, c);
    push(32'h1000_0010, 2'b00, 1'b0, c + 3);
    push(32'h1000_0011, 2'b00, 1'b0, c + 4);
    push(32'h1000_0012, 2'b00, 1'b0, c + 5);
    push(32'h1000_0013, 2'b00, 1'b1, c + 6);
    drain("incr");
    check("incr_arready_after", {31'd0, ARREADY}, 32'd1);

    // WRAP burst
    do_ar(32'h48, 8'd3, 2'b10, c);
    push(32'h1000_0012, 2'b00, 1'b0, c + 3);
    push(32'h1000_0013, 2'b00, 1'b0, c + 4);
    push(32'h1000_0010, 2'b00, 1'b0, c + 5);
    push(32'h1000_0011, 2'b00, 1'b1, c + 6);
    drain("wrap");

    // FIXED burst
    do_ar(32'h44, 8'd2, 2'b00, c);
    push(32'h1000_0011, 2'b00, 1'b0, c + 3);
    push(32'h1000_0011, 2'b00, 1'b0, c + 4);
    push(32'h1000_0011, 2'b00, 1'b1, c + 5);
    drain("fixed");

    // Backpressure
    RREADY = 1'b0;
    do_ar(32'h40, 8'd1, 2'b01, c);
    push(32'h1000_0010, 2'b00, 1'b0, c + 7);
    push(32'h1000_0011, 2'b00, 1'b1, c + 8);
    @(negedge clk);
    while (cyc < c + 3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_rvalid", {31'd0, RVALID}, 32'd1);
      check("bp_rdata", RDATA, 32'h1000_0010);
      check("bp_arready", {31'd0, ARREADY}, 32'd0);
      if (k < 4) begin
        @(posedge clk); #1;
        if (k == 3) RREADY = 1'b1;
        @(negedge clk);
      end
    end
    @(negedge clk);
    check("bp_arready_last", {31'd0, ARREADY}, 32'd0);
    drain("bp");

    // Error responses: bad WRAP length, reserved burst type
    do_ar(32'h40, 8'd2, 2'b10, c);
    push(32'h1000_0010, 2'b10, 1'b0, c + 3);
    push(32'h1000_0011, 2'b10, 1'b0, c + 4);
    push(32'h1000_0012, 2'b10, 1'b1, c + 5);
    drain("err_wrap");
    do_ar(32'h40, 8'd2, 2'b11, c);
    push(32'h1000_0010, 2'b10, 1'b0, c + 3);
    push(32'h1000_0011, 2'b10, 1'b0, c + 4);
    push(32'h1000_0012, 2'b10, 1'b1, c + 5);
    drain("err_rsvd");

    // Reset mid-burst
    do_ar(32'h40, 8'd7, 2'b01, c);
    push(32'h1000_0010, 2'b00, 1'b0, c + 3);
    push(32'h1000_0011, 2'b00, 1'b0, c + 4);
    push(32'h1000_0012, 2'b00, 1'b0, c + 5);
    @(negedge clk);
    while (cyc < c + 5) @(negedge clk);
    @(posedge clk); #1;
    RREADY = 1'b0;
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_rvalid", {31'd0, RVALID}, 32'd0);
    check("midrst_rlast", {31'd0, RLAST}, 32'd0);
    check("midrst_popped", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    RREADY = 1'b1;
    do_ar(32'h0, 8'd0, 2'b01, c);
    push(32'h1000_0000, 2'b00, 1'b1, c + 3);
    drain("post_rst");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
